// File: rtl/debounce_switch.sv
// Switch debouncer: multi-flop synchronizer, consecutive-mismatch counter,
// and registered single-cycle rise/fall pulses on each debounced edge.
module debounce_switch #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic        INIT_STATE     = 1'b0
) (
    input  logic i_Clk,
    input  logic i_reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    // Declaration initializers give a defined power-up state without reset.
    logic [SYNC_STAGES-1:0] sync_q = {SYNC_STAGES{INIT_STATE}};
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CW-1:0]          cnt_q  = '0;
    logic [CW-1:0]          cnt_d;
    logic                   sw_q   = INIT_STATE;
    logic                   sw_d;
    logic                   rise_q = 1'b0;
    logic                   fall_q = 1'b0;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_Switch};
        cnt_d  = cnt_q;
        sw_d   = sw_q;
        if (sync == sw_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            sw_d  = sync;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            sync_q <= {SYNC_STAGES{INIT_STATE}};
            cnt_q  <= '0;
            sw_q   <= INIT_STATE;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            sw_q   <= sw_d;
            rise_q <= sw_d & ~sw_q;
            fall_q <= ~sw_d & sw_q;
        end
    end

    assign o_Switch = sw_q;
    assign o_Rise   = rise_q;
    assign o_Fall   = fall_q;

endmodule

// File: tb/tb_debounce_switch.sv
// Bench for debounce_switch: directed scenarios plus random stimulus, all
// checked cycle by cycle against a windowed history model of the debouncer.
module tb_debounce_switch;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned STAGES = 2;
    localparam logic        INIT = 1'b0;

    logic i_Clk = 1'b0;
    logic i_reset = 1'b0;
    logic i_Switch = 1'b0;
    logic o_Switch, o_Rise, o_Fall;

    int n_vec = 0;
    int n_err = 0;

    // Model: delay line for the synchronizer, history of synced values,
    // and the edge index where the output last changed (or reset hit).
    logic dq[$];
    logic sh[$];
    int   lastchg = -1;
    logic m_out = INIT;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;

    debounce_switch #(
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES(STAGES),
        .INIT_STATE(INIT)
    ) dut (
        .i_Clk(i_Clk),
        .i_reset(i_reset),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_Rise(o_Rise),
        .o_Fall(o_Fall)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // The output flips at edge k only if the last LIMIT synced samples all
    // differ from it and none of them precede the last change/reset.
    task automatic model_edge(input logic sw, input logic rst);
        logic syncv;
        int   k;
        bit   flip;
        if (rst) begin
            dq.delete();
            for (int i = 0; i < int'(STAGES); i++) dq.push_back(INIT);
            sh.push_back(INIT);
            lastchg = sh.size() - 1;
            m_out  = INIT;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            syncv = dq[STAGES-1];
            dq.push_front(sw);
            void'(dq.pop_back());
            sh.push_back(syncv);
            k = sh.size() - 1;
            flip = (k - lastchg >= int'(LIMIT));
            if (flip)
                for (int i = k - int'(LIMIT) + 1; i <= k; i++)
                    if (sh[i] == m_out) flip = 1'b0;
            if (flip) begin
                m_out   = ~m_out;
                lastchg = k;
            end
            m_rise = flip && m_out;
            m_fall = flip && !m_out;
        end
    endtask

    task automatic step(input logic sw, input logic rst);
        i_Switch = sw;
        i_reset  = rst;
        @(posedge i_Clk);
        model_edge(sw, rst);
        @(negedge i_Clk);
        check("o_Switch", o_Switch, m_out);
        check("o_Rise", o_Rise, m_rise);
        check("o_Fall", o_Fall, m_fall);
        check("rise_fall_excl", o_Rise & o_Fall, 0);
    endtask

    // Hold sw for n edges; report edges until o_Switch == target (-1 if never)
    // and the number of rise/fall pulses observed.
    task automatic hold(input logic sw, input int n, input logic target,
                        output int lat, output int rises, output int falls);
        lat = -1; rises = 0; falls = 0;
        for (int i = 0; i < n; i++) begin
            step(sw, 1'b0);
            if (lat < 0 && o_Switch == target) lat = i + 1;
            rises += int'(o_Rise);
            falls += int'(o_Fall);
        end
    endtask

    initial begin
        int lat, r, f;
        int val, len;
        bit rst;

        for (int i = 0; i < int'(STAGES); i++) dq.push_back(INIT);

        // Reset with switch high: debounced level stays at INIT.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("reset_sw", o_Switch, 0);
        check("reset_rise", o_Rise, 0);
        check("reset_fall", o_Fall, 0);
        hold(1'b0, 6, 1'b1, lat, r, f);
        check("post_reset_sw", o_Switch, 0);

        // Three-clock glitch is rejected.
        hold(1'b1, 3, 1'b1, lat, r, f);
        check("glitch_lat", lat, -1);
        hold(1'b0, 10, 1'b1, lat, r, f);
        check("glitch_sw", o_Switch, 0);
        check("glitch_pulses", r + f, 0);

        // Clean press: change at edge N, output at edge N+5.
        hold(1'b1, 12, 1'b1, lat, r, f);
        check("press_lat", lat, 6);
        check("press_rise", r, 1);
        check("press_fall", f, 0);

        // Release.
        hold(1'b0, 12, 1'b0, lat, r, f);
        check("release_lat", lat, 6);
        check("release_fall", f, 1);
        check("release_rise", r, 0);

        // Bounce every 2 clocks for 20 clocks, then settle high.
        r = 0; f = 0;
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2) == 0, 1'b0);
            r += int'(o_Rise);
            f += int'(o_Fall);
        end
        check("bounce_sw", o_Switch, 0);
        check("bounce_pulses", r + f, 0);
        hold(1'b1, 12, 1'b1, lat, r, f);
        check("bounce_lat", lat, 6);
        check("bounce_rise", r, 1);

        hold(1'b0, 10, 1'b0, lat, r, f);

        // Reset pulse mid-count restarts the full latency.
        r = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            r += int'(o_Switch);
        end
        step(1'b1, 1'b1);
        r += int'(o_Switch) + int'(o_Rise) + int'(o_Fall);
        hold(1'b1, 12, 1'b1, lat, f, f);
        check("midrst_early", r, 0);
        check("midrst_lat", lat, 6);

        // Random stimulus with occasional resets.
        for (int s = 0; s < 400; s++) begin
            val = $urandom_range(0, 1);
            len = $urandom_range(1, 8);
            rst = ($urandom_range(0, 40) == 0);
            for (int j = 0; j < len; j++) step(val[0], rst && (j == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_switch.md
DEBOUNCE_SWITCH -- requirements
Module: debounce_switch

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_LIMIT, default 250000, meaning the number of consecutive clocks the synchronized input must differ from o_Switch before o_Switch updates (10 ms at 25 MHz); legal range >= 1.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops; legal range >= 2.
REQ-003 The module SHALL have parameter INIT_STATE, default 1'b0, meaning the reset/power-up level of the synchronizer flops and o_Switch.
REQ-004 i_Clk  input  1  system clock; all state updates on the rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_Switch  input  1  raw, asynchronous, bouncing switch level.
REQ-007 o_Switch  output  1  debounced level, registered.
REQ-008 o_Rise  output  1  one-clock pulse, registered, on each debounced 0->1 transition.
REQ-009 o_Fall  output  1  one-clock pulse, registered, on each debounced 1->0 transition.

Function
REQ-010 i_Switch SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync) feeds the debounce logic.
REQ-011 An internal counter of width $clog2(DEBOUNCE_LIMIT+1) SHALL hold the count of consecutive clocks with sync != o_Switch.
REQ-012 On each clock where sync == o_Switch, the counter SHALL clear to 0 and o_Switch SHALL hold.
REQ-013 On each clock where sync != o_Switch and the counter < DEBOUNCE_LIMIT-1, the counter SHALL increment by 1 and o_Switch SHALL hold.
REQ-014 On a clock where sync != o_Switch and the counter == DEBOUNCE_LIMIT-1, o_Switch SHALL take the sync value and the counter SHALL clear to 0.
REQ-015 Any single clock of sync == o_Switch during counting (bounce) SHALL restart the count from 0; partial counts never carry over.
REQ-016 Latency from a stable change of i_Switch (set up before edge N) to o_Switch changing SHALL be exactly SYNC_STAGES + DEBOUNCE_LIMIT rising edges (o_Switch updates at edge N+SYNC_STAGES+DEBOUNCE_LIMIT-1).
REQ-017 o_Rise SHALL be 1 for exactly the one clock in which o_Switch has just changed 0->1, otherwise 0; o_Fall likewise for 1->0.
REQ-018 o_Rise and o_Fall SHALL never be 1 simultaneously.
REQ-019 The counter SHALL never exceed DEBOUNCE_LIMIT-1 and SHALL never wrap.
REQ-020 With DEBOUNCE_LIMIT == 1, o_Switch SHALL follow sync with one clock of delay.

Reset
REQ-021 While i_reset is 1 at a rising edge, all synchronizer flops and o_Switch SHALL load INIT_STATE, the counter SHALL load 0, and o_Rise/o_Fall SHALL load 0, overriding all other updates.
REQ-022 Reset asserted mid-count SHALL discard the count; no o_Rise/o_Fall pulse SHALL be generated by reset itself, even if o_Switch changes level due to reset.
REQ-023 Flops SHALL also carry INIT_STATE/0 power-up initial values so the block works without reset on FPGA.
REQ-024 After reset deassertion, a changed i_Switch SHALL require the full REQ-016 latency.

Verification (DEBOUNCE_LIMIT=4, SYNC_STAGES=2, INIT_STATE=0)
REQ-025 Reset: i_reset=1 for 2 clocks with i_Switch=1 -> o_Switch=0, o_Rise=0, o_Fall=0 after release of reset at the first edge.
REQ-026 Clean press: i_Switch 0->1 before edge N, held -> o_Switch=1 after edge N+5, o_Rise=1 for that one clock only, o_Fall stays 0.
REQ-027 Glitch: i_Switch=1 for 3 clocks then 0 -> o_Switch stays 0, no pulses.
REQ-028 Bounce: i_Switch toggles every 2 clocks for 20 clocks then held 1 -> exactly one o_Rise, o_Switch=1 at 6 edges after final stable level.
REQ-029 Release: from o_Switch=1, i_Switch 1->0 held -> o_Switch=0 after 6 edges, single o_Fall pulse.
REQ-030 Reset mid-count: i_Switch=1 held, i_Reset pulsed 1 clock at edge N+3 -> o_Switch stays 0 through edge N+5 and rises only 6 edges after reset release.
